// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: LOAD phase streams a program into the imem, RUN phase fetches it.
// Optional IMEM_FETCH_PERF_EN adds saturating fetch/bubble counters.
package imem_fetch_pkg;
  typedef logic [31:0] instruction_s;
endpackage

module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic                    load_valid_i,
  input  instruction_s            load_instr_i,
  output logic                    load_ready_o,
  input  logic                    load_done_i,
  output logic [addr_width_p:0]   load_count_o,
  input  logic                    stall_i,
  input  logic                    branch_i,
  input  logic [addr_width_p-1:0] branch_target_i,
  input  logic                    halt_i,
  output logic [addr_width_p-1:0] imem_addr_o,
  output instruction_s            imem_instr_o,
  output logic                    imem_wen_o,
  output logic                    imem_nop_o,
  output logic                    instr_valid_o,
  output logic [addr_width_p-1:0] pc_o,
`ifdef IMEM_FETCH_PERF_EN
  output logic [31:0]             fetch_cnt_o,
  output logic [31:0]             bubble_cnt_o,
`endif
  output logic                    running_o
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                  state;
  logic [addr_width_p:0]   load_count;
  logic [addr_width_p-1:0] fetch_pc;
  logic [addr_width_p-1:0] pc;
  logic                    instr_valid;
  logic                    full;
  logic                    accept;

  // The MSB of the word counter doubles as the "memory full" flag.
  assign full          = load_count[addr_width_p];
  assign accept        = (state == ST_LOAD) && load_valid_i && !full;
  assign load_ready_o  = (state == ST_LOAD) && !full;
  assign load_count_o  = load_count;
  assign running_o     = (state == ST_RUN);
  assign instr_valid_o = instr_valid;
  assign pc_o          = pc;

  always_comb begin
    imem_instr_o = load_instr_i;
    imem_addr_o  = fetch_pc;
    imem_wen_o   = 1'b0;
    imem_nop_o   = 1'b1;
    case (state)
      ST_LOAD: begin
        imem_addr_o = load_count[addr_width_p-1:0];
        imem_wen_o  = accept;
      end
      ST_RUN: begin
        if (halt_i || branch_i) begin
          imem_nop_o = 1'b1;
        end else if (stall_i) begin
          // Re-read the address already on the imem output so it stays put;
          // a bubble stays a bubble.
          imem_addr_o = pc;
          imem_nop_o  = !instr_valid;
        end else begin
          imem_nop_o = 1'b0;
        end
      end
      default: begin
        imem_nop_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= ST_LOAD;
      load_count  <= '0;
      fetch_pc    <= '0;
      pc          <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          instr_valid <= 1'b0;
          if (accept) load_count <= load_count + 1'b1;
          if (load_done_i) begin
            state    <= ST_RUN;
            fetch_pc <= '0;
          end
        end
        ST_RUN: begin
          if (halt_i) begin
            state       <= ST_HALT;
            instr_valid <= 1'b0;
          end else if (branch_i) begin
            fetch_pc    <= branch_target_i;
            instr_valid <= 1'b0;
          end else if (!stall_i) begin
            pc          <= fetch_pc;
            fetch_pc    <= fetch_pc + 1'b1;
            instr_valid <= 1'b1;
          end
        end
        ST_HALT: begin
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= ST_LOAD;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else if (state == ST_RUN) begin
      if (instr_valid) fetch_cnt_o <= sat_inc(fetch_cnt_o);
      if (branch_i && !halt_i) bubble_cnt_o <= sat_inc(bubble_cnt_o);
    end
  end
`endif

endmodule
